// File: rtl/v2f_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// v2f_pkg: shared types and helpers for the v2f sequential arithmetic cells.
// Rev 1.0
// ---------------------------------------------------------------------------
package v2f_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } v2f_div_state_e;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] cond_neg(input logic [MAX_WIDTH-1:0] v,
                                                      input logic                 neg);
        return neg ? ('0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/v2f_seq_div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// v2f_seq_div_step: one restoring-division iteration (shift, trial subtract).
// Rev 1.0
// ---------------------------------------------------------------------------
module v2f_seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;

    // When the trial subtract succeeds the true difference is below the
    // divisor, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        w_shifted = {i_rem, i_dvd_bit};
        w_diff    = w_shifted[WIDTH-1:0] - i_dvs;
        o_q_bit   = (w_shifted >= {1'b0, i_dvs});
        o_rem     = o_q_bit ? w_diff : w_shifted[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/v2f_seq_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// v2f_seq_div: multi-cycle restoring divider with START/DONE handshake.
// Remainder port R present only when V2F_SEQ_DIV_REM_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
module v2f_seq_div
    import v2f_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             DIV0
`ifdef V2F_SEQ_DIV_REM_EN
    ,
    output logic [WIDTH-1:0] R
`endif
);
    localparam int               c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);

    v2f_div_state_e    state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              negq_q, negq_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div0_q, div0_d;
`ifdef V2F_SEQ_DIV_REM_EN
    logic [WIDTH-1:0]  r_q, r_d;
    logic              negr_q, negr_d;
`endif

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;

    assign w_a_neg = (SIGNED != 0) && A[WIDTH-1];
    assign w_b_neg = (SIGNED != 0) && B[WIDTH-1];
    assign w_a_abs = WIDTH'(cond_neg(MAX_WIDTH'(A), w_a_neg));
    assign w_b_abs = WIDTH'(cond_neg(MAX_WIDTH'(B), w_b_neg));

    v2f_seq_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (rem_q),
        .i_dvd_bit(quo_q[WIDTH-1]),
        .i_dvs    (dvs_q),
        .o_rem    (w_step_rem),
        .o_q_bit  (w_step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        y_d     = y_q;
        negq_d  = negq_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
`ifdef V2F_SEQ_DIV_REM_EN
        r_d     = r_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE: begin
                // A request coinciding with the DONE pulse is dropped.
                if (START && !done_q) begin
                    if (B == '0) begin
                        quo_d   = A;
                        state_d = DZ;
                    end else begin
                        quo_d   = w_a_abs;
                        dvs_d   = w_b_abs;
                        rem_d   = '0;
                        cnt_d   = c_cnt_init;
                        negq_d  = w_a_neg ^ w_b_neg;
`ifdef V2F_SEQ_DIV_REM_EN
                        negr_d  = w_a_neg;
`endif
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = {quo_q[WIDTH-2:0], w_step_q};
                rem_d = w_step_rem;
                cnt_d = cnt_q - c_cnt_w'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                y_d     = WIDTH'(cond_neg(MAX_WIDTH'(quo_q), negq_q));
`ifdef V2F_SEQ_DIV_REM_EN
                r_d     = WIDTH'(cond_neg(MAX_WIDTH'(rem_q), negr_q));
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                div0_d  = 1'b0;
                state_d = IDLE;
            end
            DZ: begin
                y_d     = '0;
`ifdef V2F_SEQ_DIV_REM_EN
                r_d     = quo_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                div0_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            y_q     <= '0;
            negq_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
`ifdef V2F_SEQ_DIV_REM_EN
            r_q     <= '0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            y_q     <= y_d;
            negq_q  <= negq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
`ifdef V2F_SEQ_DIV_REM_EN
            r_q     <= r_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Y    = y_q;
    assign DIV0 = div0_q;
`ifdef V2F_SEQ_DIV_REM_EN
    assign R    = r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_v2f_seq_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_v2f_seq_div: unsigned and signed 8-bit dividers against a behavioural model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_v2f_seq_div;

    logic       clk   = 1'b0;
    logic       arst  = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a     = 8'd0;
    logic [7:0] b     = 8'd0;

    logic       busy_u, done_u, div0_u, busy_s, done_s, div0_s;
    logic [7:0] y_u, y_s;
`ifdef V2F_SEQ_DIV_REM_EN
    logic [7:0] r_u, r_s;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    v2f_seq_div #(.WIDTH(8), .SIGNED(0)) u_dut_u (
        .CLK(clk), .ARST(arst), .START(start), .A(a), .B(b),
        .BUSY(busy_u), .DONE(done_u), .Y(y_u), .DIV0(div0_u)
`ifdef V2F_SEQ_DIV_REM_EN
        , .R(r_u)
`endif
    );

    v2f_seq_div #(.WIDTH(8), .SIGNED(1)) u_dut_s (
        .CLK(clk), .ARST(arst), .START(start), .A(a), .B(b),
        .BUSY(busy_s), .DONE(done_s), .Y(y_s), .DIV0(div0_s)
`ifdef V2F_SEQ_DIV_REM_EN
        , .R(r_s)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating signed division: quotient toward zero, remainder follows dividend.
    function automatic logic [7:0] sdiv(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, q;
        sx = int'($signed(x));
        sy = int'($signed(y));
        q  = sx / sy;
        return q[7:0];
    endfunction

    function automatic logic [7:0] smod(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sx % sy;
        return r[7:0];
    endfunction

    // Model: edges remaining until DONE, plus the results it will publish.
    int         pend = 0;
    logic       m_busy = 0, m_done = 0, m_div0 = 0, p_div0 = 0;
    logic [7:0] m_yu = 0, m_ys = 0, m_ru = 0, m_rs = 0;
    logic [7:0] p_yu = 0, p_ys = 0, p_ru = 0, p_rs = 0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            pend <= 0; m_busy <= 0; m_done <= 0; m_div0 <= 0;
            m_yu <= 0; m_ys <= 0; m_ru <= 0; m_rs <= 0;
        end else begin
            m_done <= 1'b0;
            if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    m_done <= 1'b1; m_busy <= 1'b0; m_div0 <= p_div0;
                    m_yu <= p_yu; m_ys <= p_ys; m_ru <= p_ru; m_rs <= p_rs;
                end
            end else if (start && !m_done) begin
                if (b == 8'd0) begin
                    pend <= 1; p_div0 <= 1'b1;
                    p_yu <= 8'd0; p_ys <= 8'd0; p_ru <= a; p_rs <= a;
                end else begin
                    pend <= 9; m_busy <= 1'b1; p_div0 <= 1'b0;
                    p_yu <= a / b; p_ru <= a % b;
                    p_ys <= sdiv(a, b); p_rs <= smod(a, b);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("BUSY_u", busy_u, m_busy);
        chk("BUSY_s", busy_s, m_busy);
        chk("DONE_u", done_u, m_done);
        chk("DONE_s", done_s, m_done);
        chk("DIV0_u", div0_u, m_div0);
        chk("DIV0_s", div0_s, m_div0);
        chk("Y_u", y_u, m_yu);
        chk("Y_s", y_s, m_ys);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("R_u", r_u, m_ru);
        chk("R_s", r_s, m_rs);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && (pend != 0 || m_done); i++) tick();
        chk("idle_timeout", (pend != 0 || m_done), 0);
    endtask

    // Issue one request and return edges from the sampling edge to DONE.
    task automatic op(input logic [7:0] av, input logic [7:0] bv, output int lat);
        wait_idle();
        start = 1'b1; a = av; b = bv;
        tick();
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done_u) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_u) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nd;
        repeat (3) @(posedge clk);
        #2 arst = 1'b0;
        chk("rst_busy", busy_u, 0);
        chk("rst_done", done_u, 0);
        chk("rst_y", y_u, 0);
        chk("rst_div0", div0_u, 0);

        op(8'd100, 8'd7, lat);
        chk("lat_100_7", lat, 9);
        chk("y_100_7", y_u, 14);
        chk("model_y_100_7", m_yu, 14);
        chk("div0_100_7", div0_u, 0);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("r_100_7", r_u, 2);
`endif

        op(8'hF9, 8'h02, lat);
        chk("ys_m7_2", y_s, 8'hFD);
        chk("model_ys_m7_2", m_ys, 8'hFD);
        chk("yu_249_2", y_u, 124);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("rs_m7_2", r_s, 8'hFF);
`endif

        op(8'h07, 8'hFE, lat);
        chk("ys_7_m2", y_s, 8'hFD);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("rs_7_m2", r_s, 8'h01);
`endif

        op(8'd5, 8'd0, lat);
        chk("lat_div0", lat, 1);
        chk("y_5_0", y_u, 0);
        chk("div0_5_0", div0_u, 1);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("r_5_0", r_u, 5);
`endif

        op(8'd6, 8'd3, lat);
        chk("y_6_3", y_u, 2);
        chk("div0_6_3", div0_u, 0);

        op(8'h80, 8'hFF, lat);
        chk("ys_ovf", y_s, 8'h80);
        chk("model_ys_ovf", m_ys, 8'h80);
        chk("div0_ovf", div0_s, 0);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("rs_ovf", r_s, 0);
`endif

        // Second request and operand changes while busy must be ignored.
        wait_idle();
        start = 1'b1; a = 8'd200; b = 8'd10;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 8'd50; b = 8'd5;
        tick();
        start = 1'b0; a = 8'd33; b = 8'd0;
        count_dones(25, nd);
        chk("ignore_done_count", nd, 1);
        chk("y_200_10", y_u, 20);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("r_200_10", r_u, 0);
`endif

        // Asynchronous abort in the 4th CALC cycle.
        wait_idle();
        start = 1'b1; a = 8'd100; b = 8'd3;
        tick();
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 arst = 1'b1;
        #1;
        chk("abort_busy", busy_u, 0);
        chk("abort_done", done_u, 0);
        chk("abort_y", y_u, 0);
        @(negedge clk);
        #2 arst = 1'b0;
        count_dones(15, nd);
        chk("abort_no_done", nd, 0);
        op(8'd9, 8'd4, lat);
        chk("y_9_4", y_u, 2);
        chk("lat_9_4", lat, 9);
`ifdef V2F_SEQ_DIV_REM_EN
        chk("r_9_4", r_u, 1);
`endif

        // Random traffic, including requests during BUSY and on the DONE cycle.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a     = 8'($urandom);
            b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
